// File: rtl/lampFPU_pkg.sv
// Shared FSM state type and fixed-point constants for the Goldschmidt square-root unit.
// Constants are held at 60 fraction bits and truncated to the datapath width on use.
package lampFPU_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CHECK,
        ITER_R,
        ITER_XY,
        FINAL,
        DONE
    } gs_state_e;

    localparam int CONST_FB = 60;
    localparam logic [63:0] SQRT2_Q60     = 64'h16A0_9E66_7F3B_CC90;
    localparam logic [63:0] INV_SQRT2_Q60 = 64'h0B50_4F33_3F9D_E648;

    function automatic logic [63:0] three_fxp(input int f);
        return 64'd3 << f;
    endfunction

    function automatic logic [63:0] sqrt2_fxp(input int f);
        return SQRT2_Q60 >> (CONST_FB - f);
    endfunction

    function automatic logic [63:0] inv_sqrt2_fxp(input int f);
        return INV_SQRT2_Q60 >> (CONST_FB - f);
    endfunction

    // Convergence tolerance 2^-(mant_dw+1) expressed in f fraction bits.
    function automatic logic [63:0] tol_fxp(input int f, input int mant_dw);
        return 64'd1 << (f - mant_dw - 1);
    endfunction

endpackage

// File: rtl/goldschmidt_fxp_mul.sv
// Unsigned 2.F x 2.F fixed-point multiply, truncated back to 2.F.
// Integer bits above two are dropped; operands in this unit never exceed 2.0.
module goldschmidt_fxp_mul #(
    parameter int F = 16,
    parameter int W = F + 2
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] p_o
);

    logic [2*W-1:0] full;
    logic           unused_bits;

    assign full        = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    assign p_o         = full[F +: W];
    assign unused_bits = ^{full[2*W-1:F+W], full[F-1:0]};

endmodule

// File: rtl/goldschmidt_sqrt_unit.sv
// Iterative Goldschmidt sqrt / reciprocal-sqrt of a significand in [0.5,1),
// with odd-exponent sqrt2 correction and round-to-nearest output.
module goldschmidt_sqrt_unit
    import lampFPU_pkg::*;
#(
    parameter int MANT_DW  = 8,
    parameter int PREC_DW  = 8,
    parameter int MAX_ITER = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic [MANT_DW-1:0]                s_i,
    input  logic                              is_exp_odd_i,
    input  logic                              rsqrt_i,
    input  logic                              special_case_i,
    output logic                              ready_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [MANT_DW-1:0]                res_o,
    output logic [$clog2(MAX_ITER+1)-1:0]     iter_o
);

    localparam int F  = MANT_DW + PREC_DW;
    localparam int W  = F + 2;
    localparam int NW = $clog2(MAX_ITER + 1);
    localparam int SH = F - (MANT_DW - 1);

    localparam logic [W-1:0]  THREE     = W'(three_fxp(F));
    localparam logic [W-1:0]  SQRT2     = W'(sqrt2_fxp(F));
    localparam logic [W-1:0]  INV_SQRT2 = W'(inv_sqrt2_fxp(F));
    localparam logic [W-1:0]  TOL       = W'(tol_fxp(F, MANT_DW));
    localparam logic [W-1:0]  ONE       = W'(64'd1 << F);
    localparam logic [NW-1:0] MAX_N     = NW'(MAX_ITER);

    gs_state_e          state_q, state_d;
    logic [MANT_DW-1:0] s_q, s_d, res_q, res_d;
    logic               odd_q, odd_d, rsqrt_q, rsqrt_d;
    logic [W-1:0]       b_q, b_d, r_q, r_d, x_q, x_d, y_q, y_d;
    logic [NW-1:0]      n_q, n_d, iter_q, iter_d;

    logic [W-1:0] s_ext, r_src, r_new, r_dev;
    logic [W-1:0] xa, xb, br_p, brr_p, xr_p, yr_p;
    logic [W-1:0] v_sel, corr, fin_p, v_fin;
    logic [MANT_DW+1:0] rnd;
    logic [MANT_DW-1:0] res_fin;
    logic         r_close;
    logic         unused_rnd_lsbs;

    assign s_ext = {2'b00, s_q, {PREC_DW{1'b0}}};

    // INIT seeds r from s; ITER_R refines r from the running b.
    assign r_src = (state_q == INIT) ? s_ext : b_q;
    assign r_new = (THREE - r_src) >> 1;
    assign xa    = (state_q == INIT) ? s_ext : x_q;
    assign xb    = (state_q == INIT) ? r_new : r_q;

    assign r_dev   = (r_q >= ONE) ? (r_q - ONE) : (ONE - r_q);
    assign r_close = (r_dev <= TOL);

    assign v_sel = rsqrt_q ? y_q : x_q;
    assign corr  = rsqrt_q ? INV_SQRT2 : SQRT2;
    assign v_fin = odd_q ? fin_p : v_sel;

    assign rnd     = {1'b0, v_fin[W-1:SH]} + {{(MANT_DW+1){1'b0}}, v_fin[SH-1]};
    assign res_fin = (|rnd[MANT_DW+1:MANT_DW]) ? {MANT_DW{1'b1}} : rnd[MANT_DW-1:0];
    assign unused_rnd_lsbs = ^v_fin[SH-2:0];

    goldschmidt_fxp_mul #(.F(F)) u_br  (.a_i(b_q),   .b_i(r_q),  .p_o(br_p));
    goldschmidt_fxp_mul #(.F(F)) u_brr (.a_i(br_p),  .b_i(r_q),  .p_o(brr_p));
    goldschmidt_fxp_mul #(.F(F)) u_xr  (.a_i(xa),    .b_i(xb),   .p_o(xr_p));
    goldschmidt_fxp_mul #(.F(F)) u_yr  (.a_i(y_q),   .b_i(r_q),  .p_o(yr_p));
    goldschmidt_fxp_mul #(.F(F)) u_fin (.a_i(v_sel), .b_i(corr), .p_o(fin_p));

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        odd_d   = odd_q;
        rsqrt_d = rsqrt_q;
        b_d     = b_q;
        r_d     = r_q;
        x_d     = x_q;
        y_d     = y_q;
        n_d     = n_q;
        res_d   = res_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (special_case_i) begin
                        res_d   = '0;
                        iter_d  = '0;
                        state_d = DONE;
                    end else begin
                        s_d     = s_i;
                        odd_d   = is_exp_odd_i;
                        rsqrt_d = rsqrt_i;
                        state_d = INIT;
                    end
                end
            end
            INIT: begin
                b_d     = s_ext;
                r_d     = r_new;
                x_d     = xr_p;
                y_d     = r_new;
                n_d     = '0;
                state_d = CHECK;
            end
            CHECK: begin
                if (r_close || (n_q == MAX_N)) begin
                    state_d = FINAL;
                end else begin
                    b_d     = brr_p;
                    state_d = ITER_R;
                end
            end
            ITER_R: begin
                r_d     = r_new;
                state_d = ITER_XY;
            end
            ITER_XY: begin
                x_d     = xr_p;
                y_d     = yr_p;
                n_d     = n_q + NW'(1);
                state_d = CHECK;
            end
            FINAL: begin
                res_d   = res_fin;
                iter_d  = n_q;
                state_d = DONE;
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            odd_q   <= 1'b0;
            rsqrt_q <= 1'b0;
            b_q     <= '0;
            r_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            n_q     <= '0;
            res_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            odd_q   <= odd_d;
            rsqrt_q <= rsqrt_d;
            b_q     <= b_d;
            r_q     <= r_d;
            x_q     <= x_d;
            y_q     <= y_d;
            n_q     <= n_d;
            res_q   <= res_d;
            iter_q  <= iter_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign res_o   = res_q;
    assign iter_o  = iter_q;

endmodule

// File: tb/tb_goldschmidt_sqrt_unit.sv
// Directed bench for goldschmidt_sqrt_unit at MANT_DW=8, PREC_DW=8, MAX_ITER=4.
module tb_goldschmidt_sqrt_unit;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic [7:0] s_i;
    logic       is_exp_odd_i;
    logic       rsqrt_i;
    logic       special_case_i;
    logic       ready_o;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] res_o;
    logic [2:0] iter_o;

    int checks   = 0;
    int failures = 0;

    goldschmidt_sqrt_unit #(.MANT_DW(8), .PREC_DW(8), .MAX_ITER(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .s_i            (s_i),
        .is_exp_odd_i   (is_exp_odd_i),
        .rsqrt_i        (rsqrt_i),
        .special_case_i (special_case_i),
        .ready_o        (ready_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .res_o          (res_o),
        .iter_o         (iter_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request from IDLE and measures edges (accepting edge = 1) until valid_o.
    task automatic run_op(input logic [7:0] s, input logic odd, input logic rs, input logic sp,
                          output logic [7:0] res, output logic [2:0] it, output int lat);
        @(negedge clk);
        s_i = s; is_exp_odd_i = odd; rsqrt_i = rs; special_case_i = sp; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; special_case_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (valid_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout s=%h: valid_o never rose within %0d edges", s, lat);
        end
        res = res_o;
        it  = iter_o;
        if (ready_i) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start_i = 1'b0; s_i = 8'h00; is_exp_odd_i = 1'b0;
        rsqrt_i = 1'b0; special_case_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (res_o !== 8'h00)  begin failures++; $display("FAIL reset_res got=%h exp=00", res_o); end
        checks++; if (iter_o !== 3'd0)  begin failures++; $display("FAIL reset_iter got=%0d exp=0", iter_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sqrt_half;
        logic [7:0] r; logic [2:0] it; int lat;
        run_op(8'h80, 1'b0, 1'b0, 1'b0, r, it, lat);
        checks++; if (r !== 8'h5A && r !== 8'h5B) begin failures++; $display("FAIL sqrt_half_res got=%h exp=5A/5B", r); end
        checks++; if (it !== 3'd3) begin failures++; $display("FAIL sqrt_half_iter got=%0d exp=3", it); end
        checks++; if (lat != 13)   begin failures++; $display("FAIL sqrt_half_lat got=%0d exp=13", lat); end
    endtask

    task automatic test_odd_exp;
        logic [7:0] r; logic [2:0] it; int lat;
        run_op(8'h80, 1'b1, 1'b0, 1'b0, r, it, lat);
        checks++; if (r !== 8'h80) begin failures++; $display("FAIL odd_sqrt_res got=%h exp=80", r); end
        run_op(8'h80, 1'b1, 1'b1, 1'b0, r, it, lat);
        checks++; if (r !== 8'h80) begin failures++; $display("FAIL odd_rsqrt_res got=%h exp=80", r); end
        checks++; if (it !== 3'd3) begin failures++; $display("FAIL odd_rsqrt_iter got=%0d exp=3", it); end
    endtask

    task automatic test_rsqrt;
        logic [7:0] r; logic [2:0] it; int lat;
        run_op(8'hC0, 1'b0, 1'b1, 1'b0, r, it, lat);
        checks++; if (r !== 8'h94) begin failures++; $display("FAIL rsqrt_c0_res got=%h exp=94", r); end
        checks++; if (it !== 3'd2) begin failures++; $display("FAIL rsqrt_c0_iter got=%0d exp=2", it); end
        checks++; if (lat != 10)   begin failures++; $display("FAIL rsqrt_c0_lat got=%0d exp=10", lat); end
    endtask

    // s=0xFF seeds r exactly at the tolerance edge; s=0xFE lands just outside it.
    task automatic test_tolerance_edge;
        logic [7:0] r; logic [2:0] it; int lat;
        run_op(8'hFF, 1'b0, 1'b0, 1'b0, r, it, lat);
        checks++; if (r !== 8'h80) begin failures++; $display("FAIL tol_ff_sqrt_res got=%h exp=80", r); end
        checks++; if (it !== 3'd0) begin failures++; $display("FAIL tol_ff_iter got=%0d exp=0", it); end
        checks++; if (lat != 4)    begin failures++; $display("FAIL tol_ff_lat got=%0d exp=4", lat); end
        run_op(8'hFF, 1'b0, 1'b1, 1'b0, r, it, lat);
        checks++; if (r !== 8'h80) begin failures++; $display("FAIL tol_ff_rsqrt_res got=%h exp=80", r); end
        run_op(8'hFE, 1'b0, 1'b0, 1'b0, r, it, lat);
        checks++; if (it !== 3'd1) begin failures++; $display("FAIL tol_fe_iter got=%0d exp=1", it); end
        checks++; if (r !== 8'h7F && r !== 8'h80) begin failures++; $display("FAIL tol_fe_res got=%h exp=7F/80", r); end
        checks++; if (lat != 7)    begin failures++; $display("FAIL tol_fe_lat got=%0d exp=7", lat); end
    endtask

    task automatic test_special;
        logic [7:0] r; logic [2:0] it; int lat;
        run_op(8'hC0, 1'b1, 1'b0, 1'b1, r, it, lat);
        checks++; if (lat != 1)    begin failures++; $display("FAIL special_lat got=%0d exp=1", lat); end
        checks++; if (r !== 8'h00) begin failures++; $display("FAIL special_res got=%h exp=00", r); end
        checks++; if (it !== 3'd0) begin failures++; $display("FAIL special_iter got=%0d exp=0", it); end
    endtask

    task automatic test_backpressure;
        logic [7:0] r; logic [2:0] it; int lat;
        ready_i = 1'b0;
        run_op(8'hC0, 1'b0, 1'b0, 1'b0, r, it, lat);
        checks++; if (r !== 8'h6F) begin failures++; $display("FAIL bp_res got=%h exp=6F", r); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start_i = 1'b1; s_i = 8'h80; special_case_i = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (valid_o !== 1'b1 || res_o !== 8'h6F || ready_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got valid=%b res=%h ready=%b exp 1/6F/0", c, valid_o, res_o, ready_o);
            end
        end
        @(negedge clk);
        start_i = 1'b0; special_case_i = 1'b0; ready_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_no_accept_on_handshake got=%b exp=0", ready_o); end
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++; $display("FAIL bp_release got ready=%b valid=%b exp 1/0", ready_o, valid_o);
        end
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++; $display("FAIL bp_not_queued got ready=%b valid=%b exp 1/0", ready_o, valid_o);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] r; logic [2:0] it; int lat;
        @(negedge clk);
        s_i = 8'h80; is_exp_odd_i = 1'b0; rsqrt_i = 1'b0; special_case_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || res_o !== 8'h00 || iter_o !== 3'd0) begin
            failures++;
            $display("FAIL rst_mid got ready=%b valid=%b res=%h iter=%0d exp 1/0/00/0", ready_o, valid_o, res_o, iter_o);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'hC0, 1'b0, 1'b0, 1'b0, r, it, lat);
        checks++; if (r !== 8'h6F) begin failures++; $display("FAIL rst_mid_next_res got=%h exp=6F", r); end
        checks++; if (lat != 10)   begin failures++; $display("FAIL rst_mid_next_lat got=%0d exp=10", lat); end
    endtask

    initial begin
        test_reset();
        test_sqrt_half();
        test_odd_exp();
        test_rsqrt();
        test_tolerance_edge();
        test_special();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
